// File: rtl/interleave_checker.sv
// interleave_checker
//   Self-synchronising checker for the de-interleaver output stream. It expects
//   an incrementing sequence (mod 2^DW). It locks after LOCK_CNT consecutive
//   in-sequence words and drops lock after LOSS_CNT consecutive misses. While
//   locked it reports a per-word pass/fail and keeps saturating compare and
//   error counters.
//
//   state  | meaning
//   SEARCH | no reference; the next valid word seeds exp
//   VERIFY | counting consecutive in-sequence words toward lock
//   LOCK   | locked; exp free-runs, words are scored and counted
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   dec_in       in   [DW-1:0] de-interleaved data word
//   dec_valid    in   dec_in valid this cycle
//   cnt_clr      in   synchronous clear of cmp_cnt / err_cnt
//   check_valid  out  one cycle after each accepted word
//   check_out    out  1 = word compared in LOCK and matched
//   locked       out  high while in LOCK
//   cmp_cnt      out  [CW-1:0] words compared in LOCK, saturating
//   err_cnt      out  [CW-1:0] mismatches in LOCK, saturating
module interleave_checker #(
  parameter int DW       = 12,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 4,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] dec_in,
  input  logic          dec_valid,
  input  logic          cnt_clr,
  output logic          check_valid,
  output logic          check_out,
  output logic          locked,
  output logic [CW-1:0] cmp_cnt,
  output logic [CW-1:0] err_cnt
);

  localparam int RW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(LOSS_CNT + 1);
  localparam logic [DW-1:0] ONE_DW  = DW'(1);
  localparam logic [RW-1:0] ONE_RW  = RW'(1);
  localparam logic [MW-1:0] ONE_MW  = MW'(1);
  localparam logic [CW-1:0] ONE_CW  = CW'(1);
  localparam logic [RW-1:0] LOCK_TC = RW'(LOCK_CNT);
  localparam logic [MW-1:0] LOSS_TC = MW'(LOSS_CNT);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [DW-1:0] exp, exp_d;
  logic [RW-1:0] run, run_d;
  logic [MW-1:0] miss, miss_d;
  logic          match;
  logic          cmp_evt, err_evt, pass_evt;

  assign match = (dec_in == exp);

  always_comb begin
    state_d  = state;
    exp_d    = exp;
    run_d    = run;
    miss_d   = miss;
    cmp_evt  = 1'b0;
    err_evt  = 1'b0;
    pass_evt = 1'b0;
    if (dec_valid) begin
      unique case (state)
        SEARCH: begin
          exp_d   = dec_in + ONE_DW;
          run_d   = ONE_RW;
          state_d = (LOCK_CNT == 1) ? LOCK : VERIFY;
        end
        VERIFY: begin
          if (match) begin
            exp_d = exp + ONE_DW;
            run_d = run + ONE_RW;
            if (run + ONE_RW == LOCK_TC) state_d = LOCK;
          end else begin
            // Mismatch reseeds from the current word rather than going back to SEARCH.
            exp_d = dec_in + ONE_DW;
            run_d = ONE_RW;
          end
        end
        LOCK: begin
          exp_d   = exp + ONE_DW;
          cmp_evt = 1'b1;
          if (match) begin
            miss_d   = '0;
            pass_evt = 1'b1;
          end else begin
            err_evt = 1'b1;
            miss_d  = miss + ONE_MW;
            if (miss + ONE_MW == LOSS_TC) begin
              state_d = SEARCH;
              miss_d  = '0;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEARCH;
      exp         <= '0;
      run         <= '0;
      miss        <= '0;
      check_valid <= 1'b0;
      check_out   <= 1'b0;
      locked      <= 1'b0;
      cmp_cnt     <= '0;
      err_cnt     <= '0;
    end else begin
      state       <= state_d;
      exp         <= exp_d;
      run         <= run_d;
      miss        <= miss_d;
      check_valid <= dec_valid;
      check_out   <= pass_evt;
      // Mirrors the state register so locked tracks entry/exit of LOCK exactly.
      locked      <= (state_d == LOCK);
      if (cnt_clr)                   cmp_cnt <= '0;
      else if (cmp_evt && !(&cmp_cnt)) cmp_cnt <= cmp_cnt + ONE_CW;
      if (cnt_clr)                   err_cnt <= '0;
      else if (err_evt && !(&err_cnt)) err_cnt <= err_cnt + ONE_CW;
    end
  end

endmodule

// File: tb/tb_interleave_checker.sv
module tb_interleave_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] dec_in;
  logic        dec_valid;
  logic        cnt_clr;

  logic        check_valid, check_out, locked;
  logic [15:0] cmp_cnt, err_cnt;

  logic        check_valid4, check_out4, locked4;
  logic [3:0]  cmp_cnt4, err_cnt4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  interleave_checker #(.DW(12), .LOCK_CNT(4), .LOSS_CNT(4), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .dec_in(dec_in), .dec_valid(dec_valid), .cnt_clr(cnt_clr),
    .check_valid(check_valid), .check_out(check_out), .locked(locked),
    .cmp_cnt(cmp_cnt), .err_cnt(err_cnt)
  );

  // Narrow-counter instance with a large loss threshold so it stays locked through a long error burst.
  interleave_checker #(.DW(12), .LOCK_CNT(4), .LOSS_CNT(32), .CW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .dec_in(dec_in), .dec_valid(dec_valid), .cnt_clr(cnt_clr),
    .check_valid(check_valid4), .check_out(check_out4), .locked(locked4),
    .cmp_cnt(cmp_cnt4), .err_cnt(err_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Called at a negedge; returns at the next negedge with the word's results visible.
  task automatic push(input logic [11:0] w);
    dec_in    = w;
    dec_valid = 1'b1;
    @(negedge clk);
    dec_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    dec_valid = 1'b0;
    cnt_clr   = 1'b0;
    dec_in    = '0;
    rst_n     = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic lock_on(input logic [11:0] base);
    for (int i = 0; i < 4; i++) push(base + 12'(i));
  endtask

  initial begin
    rst_n = 1'b0; dec_valid = 1'b0; cnt_clr = 1'b0; dec_in = '0;
    @(negedge clk);
    chk("rst_check_valid", 32'(check_valid), 0);
    chk("rst_check_out",   32'(check_out),   0);
    chk("rst_locked",      32'(locked),      0);
    chk("rst_cmp_cnt",     32'(cmp_cnt),     0);
    chk("rst_err_cnt",     32'(err_cnt),     0);
    do_reset();

    // 1: lock on 100..103, then 104 scores
    push(100); push(101); push(102);
    chk("t1_locked_before", 32'(locked), 0);
    push(103);
    chk("t1_locked",        32'(locked), 1);
    chk("t1_valid_103",     32'(check_valid), 1);
    chk("t1_checkout_103",  32'(check_out), 0);
    chk("t1_cmp_before",    32'(cmp_cnt), 0);
    push(104);
    chk("t1_checkout_104",  32'(check_out), 1);
    chk("t1_cmp_cnt",       32'(cmp_cnt), 1);
    chk("t1_err_cnt",       32'(err_cnt), 0);
    idle(1);
    chk("t1_valid_idle",    32'(check_valid), 0);

    // 2: wrap in LOCK
    do_reset();
    lock_on(4090);
    push(4094); chk("t2_co_4094", 32'(check_out), 1);
    push(4095); chk("t2_co_4095", 32'(check_out), 1);
    push(0);    chk("t2_co_0",    32'(check_out), 1);
    push(1);    chk("t2_co_1",    32'(check_out), 1);
    chk("t2_err_cnt", 32'(err_cnt), 0);
    chk("t2_cmp_cnt", 32'(cmp_cnt), 4);

    // 3: single error in LOCK
    do_reset();
    lock_on(196);
    push(200); chk("t3_co_200", 32'(check_out), 1);
    push(201); chk("t3_co_201", 32'(check_out), 1);
    push(999); chk("t3_co_999", 32'(check_out), 0);
    push(203); chk("t3_co_203", 32'(check_out), 1);
    chk("t3_err_cnt", 32'(err_cnt), 1);
    chk("t3_locked",  32'(locked), 1);

    // 4: loss of lock after 4 misses, then relock
    cnt_clr = 1'b1; idle(1); cnt_clr = 1'b0;
    chk("t4_clr_err", 32'(err_cnt), 0);
    push(7); push(7); push(7);
    chk("t4_locked_3miss", 32'(locked), 1);
    push(7);
    chk("t4_locked_4miss", 32'(locked), 0);
    chk("t4_err_cnt",      32'(err_cnt), 4);
    push(500); push(501); push(502);
    chk("t4_relock_early", 32'(locked), 0);
    push(503);
    chk("t4_relock",       32'(locked), 1);
    chk("t4_err_hold",     32'(err_cnt), 4);

    // 5: VERIFY reseed with gaps
    do_reset();
    push(10); idle(1); push(11); idle(2);
    push(50); idle(1); push(51); push(52);
    chk("t5_locked_52", 32'(locked), 0);
    idle(3);
    push(53);
    chk("t5_locked_53", 32'(locked), 1);
    chk("t5_co_53",     32'(check_out), 0);

    // 6a: CW=4 saturation
    do_reset();
    lock_on(0);
    chk("t6a_locked4", 32'(locked4), 1);
    for (int i = 0; i < 20; i++) push(4000);
    chk("t6a_err_sat", 32'(err_cnt4), 15);
    chk("t6a_cmp_sat", 32'(cmp_cnt4), 15);
    chk("t6a_locked4_hold", 32'(locked4), 1);

    // 6b: cnt_clr coincident with an error
    do_reset();
    lock_on(0);
    push(9);
    chk("t6b_err_pre", 32'(err_cnt), 1);
    cnt_clr = 1'b1;
    push(9);
    cnt_clr = 1'b0;
    chk("t6b_err_clr", 32'(err_cnt), 0);
    chk("t6b_cmp_clr", 32'(cmp_cnt), 0);
    chk("t6b_locked",  32'(locked), 1);

    // 6c: async reset mid-LOCK
    do_reset();
    lock_on(0);
    push(4);
    chk("t6c_co_pre",  32'(check_out), 1);
    chk("t6c_cmp_pre", 32'(cmp_cnt), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6c_valid",  32'(check_valid), 0);
    chk("t6c_co",     32'(check_out), 0);
    chk("t6c_locked", 32'(locked), 0);
    chk("t6c_cmp",    32'(cmp_cnt), 0);
    chk("t6c_err",    32'(err_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    lock_on(20);
    chk("t6c_relock", 32'(locked), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
